// File: rtl/smj_pkg.sv
// Shared types and constants for the SMJ tile pipeline stages.
package smj_pkg;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } tile_t;

    localparam logic [1:0] SUIT_HONOR     = 2'b00;
    localparam int         MAX_RANK_NUM   = 8;
    localparam int         MAX_RANK_HONOR = 6;
    localparam int         HAND_N         = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

endpackage

// File: rtl/smj_tile_check.sv
// Flags a tile whose rank is out of range for its suit (honors stop at 6, number suits at 8).
module smj_tile_check
    import smj_pkg::*;
(
    input  tile_t i_tile,
    output logic  o_bad
);

    assign o_bad = (i_tile.rank > 4'(MAX_RANK_NUM)) ||
                   ((i_tile.suit == SUIT_HONOR) && (i_tile.rank > 4'(MAX_RANK_HONOR)));

endmodule

// File: rtl/smj_hand_loader.sv
// Serial-to-parallel loader: collects five 6-bit tiles and hands them off as one hand.
// Optional SMJ_LOADER_CHECK_EN adds a sticky bad_tile flag for the assembled hand.
module smj_hand_loader
    import smj_pkg::*;
#(
    parameter int TILE_W           = 6,
    parameter bit CLEAR_ON_HANDOFF = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [TILE_W-1:0] tile_in,
    output logic              in_ready,
    input  logic              clear,
    output logic [TILE_W-1:0] hand_n0,
    output logic [TILE_W-1:0] hand_n1,
    output logic [TILE_W-1:0] hand_n2,
    output logic [TILE_W-1:0] hand_n3,
    output logic [TILE_W-1:0] hand_n4,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef SMJ_LOADER_CHECK_EN
    output logic              bad_tile,
`endif
    output logic [2:0]        tile_cnt
);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_out_valid;
    logic [TILE_W-1:0] r_slot [HAND_N];
    logic              w_accept;
    logic              w_bad;

    assign in_ready  = (r_state != FULL);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign tile_cnt  = r_cnt;
    assign hand_n0   = r_slot[0];
    assign hand_n1   = r_slot[1];
    assign hand_n2   = r_slot[2];
    assign hand_n3   = r_slot[3];
    assign hand_n4   = r_slot[4];

`ifdef SMJ_LOADER_CHECK_EN
    logic r_bad;

    smj_tile_check u_check (
        .i_tile (tile_t'(tile_in)),
        .o_bad  (w_bad)
    );

    // Sticky over the fill; the FULL state never accepts, so it is frozen while out_valid=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bad <= 1'b0;
        else if (clear || (r_out_valid && out_ready))
            r_bad <= 1'b0;
        else if (w_accept)
            r_bad <= r_bad | w_bad;
    end

    assign bad_tile = r_bad;
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < HAND_N; i++) r_slot[i] <= '0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < HAND_N; i++) r_slot[i] <= '0;
        end else begin
            case (r_state)
                IDLE, FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < HAND_N; i++)
                            if (3'(i) == r_cnt) r_slot[i] <= tile_in;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'(HAND_N - 1)) begin
                            r_state     <= FULL;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= FILL;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_cnt       <= 3'd0;
                        r_out_valid <= 1'b0;
                        if (CLEAR_ON_HANDOFF)
                            for (int i = 0; i < HAND_N; i++) r_slot[i] <= '0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= 3'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smj_hand_loader.sv
// Scoreboard bench for smj_hand_loader: directed plan items plus randomized traffic.
module tb_smj_hand_loader;

    typedef logic [4:0][5:0] hand_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] tile_in = 6'h00;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid;
    logic [5:0] hand_n0, hand_n1, hand_n2, hand_n3, hand_n4;
    logic [2:0] tile_cnt;
`ifdef SMJ_LOADER_CHECK_EN
    logic       bad_tile;
`endif

    int checks = 0;
    int failures = 0;

    logic [5:0] m_hand[$];
    hand_t      exp_q[$];
    logic [5:0] dut_h [5];

    assign dut_h[0] = hand_n0;
    assign dut_h[1] = hand_n1;
    assign dut_h[2] = hand_n2;
    assign dut_h[3] = hand_n3;
    assign dut_h[4] = hand_n4;

    smj_hand_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .tile_in   (tile_in),
        .in_ready  (in_ready),
        .clear     (clear),
        .hand_n0   (hand_n0),
        .hand_n1   (hand_n1),
        .hand_n2   (hand_n2),
        .hand_n3   (hand_n3),
        .hand_n4   (hand_n4),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SMJ_LOADER_CHECK_EN
        .bad_tile  (bad_tile),
`endif
        .tile_cnt  (tile_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic tile_bad(input logic [5:0] t);
        return (t[3:0] > 4'd8) || (t[5:4] == 2'b00 && t[3:0] > 4'd6);
    endfunction

    // Reference: a list of accepted tiles; full when it holds five.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hand.delete();
            exp_q.delete();
        end else if (clear) begin
            if (m_hand.size() == 5 && exp_q.size() > 0) void'(exp_q.pop_back());
            m_hand.delete();
        end else if (m_hand.size() == 5) begin
            if (out_ready) m_hand.delete();
        end else if (in_valid) begin
            m_hand.push_back(tile_in);
            if (m_hand.size() == 5) begin
                hand_t h;
                for (int i = 0; i < 5; i++) h[i] = m_hand[i];
                exp_q.push_back(h);
            end
        end
    end

    // Per-cycle state check, after the edge has settled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("tile_cnt", 32'(tile_cnt), 32'(m_hand.size()));
                chk("out_valid", 32'(out_valid), 32'(m_hand.size() == 5));
                chk("in_ready", 32'(in_ready), 32'(m_hand.size() != 5));
                for (int i = 0; i < 5; i++)
                    chk($sformatf("slot%0d", i), 32'(dut_h[i]),
                        32'((i < m_hand.size()) ? m_hand[i] : 6'h00));
            end
        end
    end

    // Handoff monitor: pops the scoreboard whenever the DUT hands a hand downstream.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clear) begin
            if (exp_q.size() == 0) begin
                chk("handoff_expected", 32'd1, 32'd0);
            end else begin
                hand_t h;
                logic  b;
                h = exp_q.pop_front();
                b = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    chk($sformatf("handoff_slot%0d", i), 32'(dut_h[i]), 32'(h[i]));
                    b = b | tile_bad(h[i]);
                end
`ifdef SMJ_LOADER_CHECK_EN
                chk("bad_tile", 32'(bad_tile), 32'(b));
`endif
            end
        end
    end

    task automatic cyc(input logic v, input logic [5:0] t, input logic ordy, input logic clr);
        in_valid  = v;
        tile_in   = t;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [5:0] basic [5];
        basic = '{6'h11, 6'h11, 6'h23, 6'h24, 6'h25};

        repeat (2) @(posedge clk);
        #2;
        chk("reset_cnt", 32'(tile_cnt), 32'd0);
        chk("reset_ovalid", 32'(out_valid), 32'd0);
        chk("reset_h0", 32'(hand_n0), 32'd0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // Reset mid-fill
        cyc(1, 6'h11, 0, 0);
        cyc(1, 6'h12, 0, 0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_cnt", 32'(tile_cnt), 32'd0);
        chk("rst_mid_ovalid", 32'(out_valid), 32'd0);
        chk("rst_mid_h0", 32'(hand_n0), 32'd0);
        chk("rst_mid_h1", 32'(hand_n1), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rst_rel_ready", 32'(in_ready), 32'd1);
        cyc(0, 0, 0, 0);

        // Basic fill with out_ready held high
        for (int i = 0; i < 5; i++) cyc(1, basic[i], 1, 0);
        chk("basic_ovalid", 32'(out_valid), 32'd1);
        chk("basic_h4", 32'(hand_n4), 32'h25);
        cyc(0, 0, 1, 0);
        chk("basic_after_cnt", 32'(tile_cnt), 32'd0);

        // Backpressure
        for (int i = 0; i < 5; i++) cyc(1, 6'h21 + 6'(i), 0, 0);
        repeat (10) cyc(1, 6'h31, 0, 0);
        chk("bp_ready", 32'(in_ready), 32'd0);
        cyc(1, 6'h31, 1, 0);
        cyc(1, 6'h31, 0, 0);
        chk("bp_slot0", 32'(hand_n0), 32'h31);
        chk("bp_cnt", 32'(tile_cnt), 32'd1);
        cyc(0, 0, 0, 1);

        // Gapped input
        for (int i = 0; i < 5; i++) begin
            cyc(1, 6'h01 + 6'(i), 0, 0);
            cyc(0, 6'h3f, 0, 0);
        end
        cyc(0, 0, 1, 0);

        // Clear mid-fill with a tile present, then clear in FULL with out_ready
        for (int i = 0; i < 3; i++) cyc(1, 6'h14 + 6'(i), 0, 0);
        cyc(1, 6'h18, 0, 1);
        chk("clr_cnt", 32'(tile_cnt), 32'd0);
        chk("clr_h0", 32'(hand_n0), 32'd0);
        for (int i = 0; i < 5; i++) cyc(1, 6'h32 + 6'(i), 0, 0);
        cyc(0, 0, 1, 1);
        chk("clr_full_ovalid", 32'(out_valid), 32'd0);
        cyc(0, 0, 0, 0);

        // Bad-tile hands
        cyc(1, 6'h07, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 6'h11, 0, 0);
`ifdef SMJ_LOADER_CHECK_EN
        chk("bad_set", 32'(bad_tile), 32'd1);
`endif
        cyc(0, 0, 1, 0);
        cyc(1, 6'h01, 0, 0);
        cyc(1, 6'h01, 0, 0);
        cyc(1, 6'h01, 0, 0);
        cyc(1, 6'h16, 0, 0);
        cyc(1, 6'h16, 0, 0);
`ifdef SMJ_LOADER_CHECK_EN
        chk("bad_clr", 32'(bad_tile), 32'd0);
`endif
        cyc(0, 0, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++)
            cyc(($urandom % 4) != 0, 6'($urandom), ($urandom % 3) == 0, ($urandom % 40) == 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
